aes_red_state_decoder: RTL and testbench

Output-side decoder for the redundancy-protected AES-128 encryption core. Consumes two independently masked redundant copies of the final 16-byte state, each byte being an L-bit polynomial over GF(2). It reduces each copy modulo the AES polynomial, one byte per cycle, and cross-checks the copies. On agreement it presents the plain 128-bit ciphertext through a valid/ready handshake; on any mismatch it locks into a fault state.

---
 rtl/aes_red_pkg.sv | 16 +
 rtl/red_mod_aes.sv | 27 ++
 rtl/aes_red_state_decoder.sv | 107 ++++++++++
 tb/tb_aes_red_state_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_red_pkg.sv
// Shared definitions for the redundant AES state decoder: FSM encoding,
// reduction polynomial and block geometry.
package aes_red_pkg;

  localparam logic [8:0] AES_POLY = 9'h11B;
  localparam int         NB       = 16;
  localparam int         IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_OUT    = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

endpackage

// File: rtl/red_mod_aes.sv
// Combinational reducer: remainder of an L-bit GF(2) polynomial modulo POLY,
// taken from the top bit downwards.
module red_mod_aes
  import aes_red_pkg::*;
#(
  parameter int         L    = 16,
  parameter logic [8:0] POLY = AES_POLY
) (
  input  logic [L-1:0] a_i,
  output logic [7:0]   r_o
);

  logic [L-1:0] poly_ext;
  logic [L-1:0] rem;

  // NOTE: blocking assignments here because rem is updated in place by each
  // loop step; this is pure combinational logic, not state.
  always_comb begin
    poly_ext = L'(POLY);
    rem      = a_i;
    for (int i = L - 1; i >= 8; i--) begin
      if (rem[i]) rem = rem ^ (poly_ext << (i - 8));
    end
    r_o = rem[7:0];
  end

endmodule

// File: rtl/aes_red_state_decoder.sv
// Reduces two independently masked redundant AES state copies one byte per
// cycle, cross-checks them and hands out the ciphertext or locks into FAULT.
module aes_red_state_decoder #(
  parameter int         L        = 16,
  parameter logic [8:0] AES_POLY = aes_red_pkg::AES_POLY
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [16*L-1:0]   state_a_i,
  input  logic [16*L-1:0]   state_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [127:0]      data_o,
  output logic              fault_o
);
  import aes_red_pkg::*;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                mis_q, mis_d;
  logic [NB*L-1:0]     sha_q, sha_d;
  logic [NB*L-1:0]     shb_q, shb_d;
  logic [127:0]        data_q, data_d;
  logic [7:0]          rem_a, rem_b;
  logic                mis_hit;

  // Two separate reducers so a single fault cannot corrupt both copies alike.
  red_mod_aes #(.L(L), .POLY(AES_POLY)) u_red_a (
    .a_i (sha_q[L-1:0]),
    .r_o (rem_a)
  );

  red_mod_aes #(.L(L), .POLY(AES_POLY)) u_red_b (
    .a_i (shb_q[L-1:0]),
    .r_o (rem_b)
  );

  assign mis_hit = (rem_a != rem_b);

  // NOTE: every variable gets its hold value first so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          sha_d   = state_a_i;
          shb_d   = state_b_i;
          cnt_d   = '0;
          mis_d   = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        data_d[cnt_q*8 +: 8] = rem_a;
        mis_d = mis_q | mis_hit;
        sha_d = sha_q >> L;
        shb_d = shb_q >> L;
        cnt_d = cnt_q + 1'b1;
        // Last byte: a mismatch found on this very cycle must also count.
        if (cnt_q == IDX_W'(NB - 1)) state_d = mis_d ? ST_FAULT : ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the shift and data registers are reset too, so an aborted block
  // leaves no bytes behind for the next one or on data_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge values of its neighbours.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      sha_q   <= '0;
      shb_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = rst_ni && (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_OUT);
  assign fault_o     = (state_q == ST_FAULT);
  assign data_o      = fault_o ? 128'd0 : data_q;

endmodule

// File: tb/tb_aes_red_state_decoder.sv
// Bench for aes_red_state_decoder: stimulus built by encoding known bytes as
// c + m(x)*P(x), so the expected output is the plain byte c.
module tb_aes_red_state_decoder;

  localparam int         L    = 16;
  localparam logic [8:0] POLY = 9'h11B;
  localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [16*L-1:0] state_a_i = '0;
  logic [16*L-1:0] state_b_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b1;
  logic [127:0]    data_o;
  logic            fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  aes_red_state_decoder #(.L(L), .AES_POLY(POLY)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .state_a_i   (state_a_i),
    .state_b_i   (state_b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .fault_o     (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Carry-less product m(x)*P(x) added to byte c: a valid redundant encoding.
  function automatic logic [L-1:0] enc(input logic [7:0] c, input logic [L-9:0] m);
    logic [L-1:0] acc;
    acc = L'(c);
    for (int i = 0; i < L - 8; i++)
      if (m[i]) acc = acc ^ (L'(POLY) << i);
    return acc;
  endfunction

  function automatic logic [16*L-1:0] build(input logic [127:0] ct, input bit rnd);
    logic [16*L-1:0] v;
    for (int k = 0; k < 16; k++)
      v[k*L +: L] = enc(ct[k*8 +: 8], rnd ? (L-8)'($urandom) : '0);
    return v;
  endfunction

  function automatic logic [16*L-1:0] junk();
    logic [16*L-1:0] v;
    for (int k = 0; k < 16; k++) v[k*L +: L] = L'($urandom);
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_fault", fault_o, 0);
    tick();
    rst_ni = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready_o, 1);
  endtask

  // Offers a pair, returns just after the accept edge E0 with inputs scrambled.
  task automatic send(input logic [16*L-1:0] a, input logic [16*L-1:0] b, input string tag);
    int w = 0;
    while (!in_ready_o && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, in_ready_o, 1);
    state_a_i  = a;
    state_b_i  = b;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    state_a_i  = junk();
    state_b_i  = junk();
  endtask

  // From E0 runs to E16 and checks the final outcome and its exact latency.
  task automatic finish_block(input bit exp_fault, input logic [127:0] exp_data, input string tag);
    repeat (15) tick();
    check({tag, "_early_flags"}, {out_valid_o, fault_o}, 0);
    tick();
    check({tag, "_out_valid"}, out_valid_o, !exp_fault);
    check({tag, "_fault"}, fault_o, exp_fault);
    check({tag, "_data"}, data_o, exp_fault ? 128'd0 : exp_data);
    if (exp_fault) check({tag, "_in_ready"}, in_ready_o, 0);
  endtask

  initial begin
    logic [16*L-1:0] a, b, err;
    logic [127:0]    exp, held;
    int              idx;

    // Reset state
    do_reset();

    // Trivial encoding: byte k = k, upper bits zero
    a = '0;
    for (int k = 0; k < 16; k++) a[k*L +: L] = L'(k);
    send(a, a, "triv");
    finish_block(0, 128'h0F0E0D0C0B0A09080706050403020100, "triv");
    tick();
    check("triv_back_idle", in_ready_o, 1);
    check("triv_valid_drop", out_valid_o, 0);

    // Reduction edges
    a = '0;
    a[0*L +: L] = L'(16'h0100);
    a[1*L +: L] = L'(16'h0200);
    a[2*L +: L] = L'(16'h011B);
    send(a, a, "edges");
    finish_block(0, 128'h0000000000000000000000000000361B, "edges");
    tick();

    // FIPS-197 ciphertext with backpressure in OUT
    out_ready_i = 1'b0;
    send(build(CT, 1), build(CT, 1), "fips_bp");
    finish_block(0, CT, "fips_bp");
    held = data_o;
    in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid_hold", out_valid_o, 1);
      check("bp_data_stable", data_o, held);
      check("bp_in_ready_low", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_release_valid", out_valid_o, 0);
    check("bp_release_idle", in_ready_o, 1);
    in_valid_i = 1'b0;

    // Fault: single-bit difference in byte 5
    a = build(CT, 1);
    b = a;
    b[5*L +: L] = b[5*L +: L] ^ L'(1);
    send(a, b, "fault5");
    finish_block(1, 128'd0, "fault5");
    in_valid_i = 1'b1;
    repeat (4) tick();
    check("fault5_sticky", fault_o, 1);
    check("fault5_no_valid", out_valid_o, 0);
    check("fault5_no_ready", in_ready_o, 0);
    check("fault5_data_zero", data_o, 0);
    do_reset();

    // Fault found only on the last byte
    a = build(CT, 1);
    b = a;
    b[15*L +: L] = b[15*L +: L] ^ enc(8'h80, '0);
    send(a, b, "fault15");
    finish_block(1, 128'd0, "fault15");
    do_reset();

    // Reset at E8, then a fresh block decodes with no leftover bytes
    send(build(128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 1),
         build(128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 1), "mid");
    repeat (8) tick();
    rst_ni = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready_o, 0);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_fault", fault_o, 0);
    tick();
    rst_ni = 1'b1;
    #1;
    exp = 128'h00000000000000000000000000000042;
    send(build(exp, 1), build(exp, 1), "after_mid");
    finish_block(0, exp, "after_mid");
    tick();

    // 1000 random encodings of the FIPS ciphertext, back to back
    for (int n = 0; n < 1000; n++) begin
      send(build(CT, 1), build(CT, 1), "rnd_fips");
      finish_block(0, CT, "rnd_fips");
      tick();
      check("rnd_fips_throughput", in_ready_o, 1);
    end

    // Random plaintexts with random mismatches
    for (int n = 0; n < 40; n++) begin
      exp = rand128();
      a = build(exp, 1);
      b = build(exp, 1);
      if (n % 2 == 1) begin
        idx = $urandom_range(15, 0);
        err = '0;
        err[idx*L +: L] = enc(8'($urandom_range(255, 1)), (L-8)'($urandom));
        b = b ^ err;
        send(a, b, "rnd_fault");
        finish_block(1, 128'd0, "rnd_fault");
        do_reset();
      end else begin
        send(a, b, "rnd_ok");
        finish_block(0, exp, "rnd_ok");
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
